// File: rtl/btpipe_out_buffer_pkg.sv
// Shared constants and width helpers for the okBTPipeOut output buffer.
//   WORD_W          : data word width (32)
//   DEF_DEPTH       : default FIFO capacity in words
//   DEF_BLOCK_SIZE  : default words per okBTPipeOut block
//   addr_w / ptr_w  : RAM address width and wrap-bit pointer width for a depth
package btpipe_out_buffer_pkg;

    localparam int WORD_W         = 32;
    localparam int DEF_DEPTH      = 1024;
    localparam int DEF_BLOCK_SIZE = 256;

    // Address width of a RAM with 'depth' entries.
    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

    // Pointer width with one extra bit so full and empty are distinguishable.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/btpipe_out_buffer_if.sv
// Producer / okBTPipeOut side bundle of the output buffer.
//   src_valid, src_data, src_ready     : producer push handshake
//   pipe_out_read, pipe_out_data       : ep_read strobe and ep_datain head word
//   pipe_out_ready                     : a full block is available (ep_ready)
//   fill_level, underflow_count        : status for wire-outs
// modport slave is the buffer itself; modport master is the surrounding logic.
interface btpipe_out_buffer_if
    import btpipe_out_buffer_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) ();

    localparam int PW = ptr_w(DEPTH);

    logic              src_valid;
    logic [WORD_W-1:0] src_data;
    logic              src_ready;
    logic              pipe_out_read;
    logic [WORD_W-1:0] pipe_out_data;
    logic              pipe_out_ready;
    logic [PW-1:0]     fill_level;
    logic [31:0]       underflow_count;

    modport master (
        output src_valid, src_data, pipe_out_read,
        input  src_ready, pipe_out_data, pipe_out_ready, fill_level, underflow_count
    );

    modport slave (
        input  src_valid, src_data, pipe_out_read,
        output src_ready, pipe_out_data, pipe_out_ready, fill_level, underflow_count
    );

endinterface

// File: rtl/btpipe_buf_ram.sv
// Simple dual-port synchronous RAM backing the output buffer.
//   clk       : clock
//   wr_en_i   : write enable, wr_addr_i / wr_data_i written on the edge
//   rd_addr_i : read address, rd_data_o valid the cycle after the edge
// A read of the address written on the same edge returns the old contents;
// the caller bypasses that case itself. No reset, so it maps to block RAM.
module btpipe_buf_ram
    import btpipe_out_buffer_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    localparam int AW   = addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [AW-1:0]     wr_addr_i,
    input  logic [WORD_W-1:0] wr_data_i,
    input  logic [AW-1:0]     rd_addr_i,
    output logic [WORD_W-1:0] rd_data_o
);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rd_data_q;

    // Write port.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Registered read port (read-first).
    always_ff @(posedge clk) begin
        rd_data_q <= mem_q[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/btpipe_out_buffer.sv
// First-word-fall-through FIFO feeding an okBTPipeOut endpoint.
//   clk     : okClk
//   reset_n : asynchronous active-low reset
//   flush   : synchronous clear of contents and status
//   bus     : slave side of btpipe_out_buffer_if (push, pop, status)
// The head word lives in an output register. The RAM is always read at the
// address just behind the next head, so on a pop the following word is
// already available; a word written to that very address on the same edge is
// caught in a one-word bypass register instead.
module btpipe_out_buffer
    import btpipe_out_buffer_pkg::*;
#(
    parameter int DEPTH      = DEF_DEPTH,
    parameter int BLOCK_SIZE = DEF_BLOCK_SIZE
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               flush,
    btpipe_out_buffer_if.slave bus
);

    localparam int AW = addr_w(DEPTH);
    localparam int PW = ptr_w(DEPTH);

    localparam logic [PW-1:0] ZERO_C  = {PW{1'b0}};
    localparam logic [PW-1:0] ONE_C   = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0] TWO_C   = {{(PW-2){1'b0}}, 2'b10};
    localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
    localparam logic [PW-1:0] BLOCK_C = PW'(BLOCK_SIZE);

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [WORD_W-1:0] dout_q, dout_d;
    logic              blk_ready_q, blk_ready_d;
    logic [31:0]       ufl_q, ufl_d;
    logic              byp_sel_q, byp_sel_d;
    logic [WORD_W-1:0] byp_data_q, byp_data_d;
    logic              live_q;

    logic [PW-1:0]     fill_s;
    logic [PW-1:0]     fill_next_s;
    logic              src_ready_s;
    logic              push_s;
    logic              pop_s;
    logic              under_s;
    logic [AW-1:0]     ram_raddr_s;
    logic [WORD_W-1:0] ram_rdata_s;
    logic [WORD_W-1:0] next_word_s;

    // live_q holds src_ready low until the first edge after reset release.
    assign fill_s      = wr_ptr_q - rd_ptr_q;
    assign src_ready_s = live_q & (fill_s < DEPTH_C) & ~flush;
    assign push_s      = bus.src_valid & src_ready_s;
    assign pop_s       = bus.pipe_out_read & (fill_s != ZERO_C) & ~flush;
    assign under_s     = bus.pipe_out_read & (fill_s == ZERO_C) & ~flush;
    assign fill_next_s = wr_ptr_d - rd_ptr_d;

    // Prefetch the word that will follow the next head.
    assign ram_raddr_s = rd_ptr_d[AW-1:0] + AW'(1'b1);
    assign next_word_s = byp_sel_q ? byp_data_q : ram_rdata_s;

    btpipe_buf_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (push_s),
        .wr_addr_i (wr_ptr_q[AW-1:0]),
        .wr_data_i (bus.src_data),
        .rd_addr_i (ram_raddr_s),
        .rd_data_o (ram_rdata_s)
    );

    // Pointer, block-ready and underflow next state.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        ufl_d       = ufl_q;
        blk_ready_d = 1'b0;
        if (flush) begin
            wr_ptr_d = ZERO_C;
            rd_ptr_d = ZERO_C;
            ufl_d    = 32'h0000_0000;
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + ONE_C;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + ONE_C;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            if (under_s && (ufl_q != 32'hFFFF_FFFF)) begin
                ufl_d = ufl_q + 32'd1;
            end else begin
                ufl_d = ufl_q;
            end
        end
        // Block ready is taken from the next-state count so it lines up with fill_level.
        if (flush) begin
            blk_ready_d = 1'b0;
        end else begin
            blk_ready_d = (fill_next_s >= BLOCK_C);
        end
    end

    // Head register and same-address bypass next state.
    always_comb begin
        dout_d     = dout_q;
        byp_sel_d  = 1'b0;
        byp_data_d = byp_data_q;
        if (flush) begin
            dout_d     = {WORD_W{1'b0}};
            byp_sel_d  = 1'b0;
            byp_data_d = {WORD_W{1'b0}};
        end else begin
            if (pop_s && (fill_s >= TWO_C)) begin
                dout_d = next_word_s;
            end else if (push_s && (fill_s == (pop_s ? ONE_C : ZERO_C))) begin
                // The pushed word becomes the head directly.
                dout_d = bus.src_data;
            end else begin
                dout_d = dout_q;
            end
            // A write landing on the prefetch address is missed by the read-first RAM.
            if (push_s && (wr_ptr_q[AW-1:0] == ram_raddr_s)) begin
                byp_sel_d  = 1'b1;
                byp_data_d = bus.src_data;
            end else begin
                byp_sel_d  = 1'b0;
                byp_data_d = byp_data_q;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= ZERO_C;
            rd_ptr_q    <= ZERO_C;
            dout_q      <= {WORD_W{1'b0}};
            blk_ready_q <= 1'b0;
            ufl_q       <= 32'h0000_0000;
            byp_sel_q   <= 1'b0;
            byp_data_q  <= {WORD_W{1'b0}};
            live_q      <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            dout_q      <= dout_d;
            blk_ready_q <= blk_ready_d;
            ufl_q       <= ufl_d;
            byp_sel_q   <= byp_sel_d;
            byp_data_q  <= byp_data_d;
            live_q      <= 1'b1;
        end
    end

    assign bus.src_ready       = src_ready_s;
    assign bus.pipe_out_data   = dout_q;
    assign bus.pipe_out_ready  = blk_ready_q;
    assign bus.fill_level      = fill_s;
    assign bus.underflow_count = ufl_q;

endmodule

// File: tb/tb_btpipe_out_buffer.sv
// Self-checking bench for btpipe_out_buffer (DEPTH=1024, BLOCK_SIZE=256).
// A queue-based model predicts every output; a negedge process compares the
// DUT against it each cycle, and directed phases add literal expectations.
module tb_btpipe_out_buffer;

    localparam int DEPTH = 1024;
    localparam int BLOCK = 256;

    logic clk;
    logic reset_n;
    logic flush;

    btpipe_out_buffer_if #(.DEPTH(DEPTH)) bus_if ();

    btpipe_out_buffer #(
        .DEPTH      (DEPTH),
        .BLOCK_SIZE (BLOCK)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .bus     (bus_if)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] mq[$];
    logic [31:0] m_head   = 32'h0;
    logic [31:0] m_uf     = 32'h0;
    bit          m_pready = 1'b0;
    bit          m_alive  = 1'b0;
    bit          m_rdy;
    bit          cmp_en   = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: FIFO as a queue, updated on every edge with the same inputs the DUT sees.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
            m_head   = 32'h0;
            m_uf     = 32'h0;
            m_pready = 1'b0;
            m_alive  = 1'b0;
        end else begin
            m_rdy = m_alive && (mq.size() < DEPTH) && !flush;
            if (flush) begin
                mq.delete();
                m_head   = 32'h0;
                m_uf     = 32'h0;
                m_pready = 1'b0;
            end else begin
                if (bus_if.pipe_out_read) begin
                    if (mq.size() == 0) begin
                        if (m_uf != 32'hFFFF_FFFF) m_uf = m_uf + 32'd1;
                    end else begin
                        void'(mq.pop_front());
                    end
                end
                if (bus_if.src_valid && m_rdy) mq.push_back(bus_if.src_data);
                if (mq.size() != 0) m_head = mq[0];
                m_pready = (mq.size() >= BLOCK);
            end
            m_alive = 1'b1;
        end
    end

    // Compare DUT against model every cycle, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("mdl_src_ready", 32'(bus_if.src_ready),
                32'(m_alive && (mq.size() < DEPTH) && !flush));
            chk("mdl_fill_level", 32'(bus_if.fill_level), 32'(mq.size()));
            chk("mdl_pipe_out_ready", 32'(bus_if.pipe_out_ready), 32'(m_pready));
            chk("mdl_underflow_count", bus_if.underflow_count, m_uf);
            chk("mdl_pipe_out_data", bus_if.pipe_out_data, m_head);
        end
    end

    initial begin
        reset_n              = 1'b1;
        flush                = 1'b0;
        bus_if.src_valid     = 1'b0;
        bus_if.src_data      = 32'h0;
        bus_if.pipe_out_read = 1'b0;
        #2;
        reset_n = 1'b0;
        cmp_en  = 1'b1;
        step();
        step();
        chk("rst_src_ready", 32'(bus_if.src_ready), 32'd0);
        chk("rst_fill", 32'(bus_if.fill_level), 32'd0);
        chk("rst_data", bus_if.pipe_out_data, 32'd0);
        chk("rst_pready", 32'(bus_if.pipe_out_ready), 32'd0);
        chk("rst_uf", bus_if.underflow_count, 32'd0);
        reset_n = 1'b1;
        step();
        chk("rst_rel_src_ready", 32'(bus_if.src_ready), 32'd1);

        // Fill 0..1023, watching the block threshold.
        bus_if.src_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            bus_if.src_data = 32'(i);
            step();
            if (i == 254) begin
                chk("blk255_pready", 32'(bus_if.pipe_out_ready), 32'd0);
                chk("blk255_fill", 32'(bus_if.fill_level), 32'd255);
            end
            if (i == 255) begin
                chk("blk256_pready", 32'(bus_if.pipe_out_ready), 32'd1);
                chk("blk256_fill", 32'(bus_if.fill_level), 32'd256);
            end
        end

        // Full: keep pushing, nothing may enter.
        bus_if.src_data = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) step();
        chk("full_src_ready", 32'(bus_if.src_ready), 32'd0);
        chk("full_fill", 32'(bus_if.fill_level), 32'd1024);
        chk("full_head", bus_if.pipe_out_data, 32'd0);

        bus_if.src_valid     = 1'b0;
        bus_if.pipe_out_read = 1'b1;
        step();
        chk("pop1_src_ready", 32'(bus_if.src_ready), 32'd1);
        chk("pop1_fill", 32'(bus_if.fill_level), 32'd1023);

        // Continuous read of the remaining words.
        for (int i = 1; i < DEPTH; i++) begin
            chk("seq_data", bus_if.pipe_out_data, 32'(i));
            step();
        end
        bus_if.pipe_out_read = 1'b0;
        chk("drain_fill", 32'(bus_if.fill_level), 32'd0);
        chk("drain_uf", bus_if.underflow_count, 32'd0);

        // Three reads while empty.
        for (int i = 0; i < 3; i++) begin
            bus_if.pipe_out_read = 1'b1;
            step();
            bus_if.pipe_out_read = 1'b0;
            step();
        end
        chk("uf3_count", bus_if.underflow_count, 32'd3);
        chk("uf3_fill", 32'(bus_if.fill_level), 32'd0);
        chk("uf3_data", bus_if.pipe_out_data, 32'd1023);

        // Concurrent push and pop across the pointer wrap.
        bus_if.src_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus_if.src_data = $urandom;
            step();
        end
        bus_if.pipe_out_read = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            bus_if.src_data = $urandom;
            step();
        end
        bus_if.src_valid     = 1'b0;
        bus_if.pipe_out_read = 1'b0;
        chk("conc_fill", 32'(bus_if.fill_level), 32'd10);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 3000; i++) begin
            bus_if.src_valid     = 1'($urandom_range(0, 1));
            bus_if.src_data      = $urandom;
            bus_if.pipe_out_read = ($urandom_range(0, 2) == 0);
            flush                = ($urandom_range(0, 99) == 0);
            step();
        end
        bus_if.src_valid     = 1'b0;
        bus_if.pipe_out_read = 1'b0;
        flush                = 1'b1;
        step();
        flush = 1'b0;

        // Flush with 300 words buffered and a non-zero underflow count.
        for (int i = 0; i < 2; i++) begin
            bus_if.pipe_out_read = 1'b1;
            step();
            bus_if.pipe_out_read = 1'b0;
            step();
        end
        chk("pre_flush_uf", bus_if.underflow_count, 32'd2);
        bus_if.src_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            bus_if.src_data = 32'(i + 100);
            step();
        end
        bus_if.src_valid = 1'b0;
        chk("pre_flush_fill", 32'(bus_if.fill_level), 32'd300);
        flush = 1'b1;
        #1;
        chk("flush_src_ready", 32'(bus_if.src_ready), 32'd0);
        step();
        flush = 1'b0;
        chk("flush_fill", 32'(bus_if.fill_level), 32'd0);
        chk("flush_data", bus_if.pipe_out_data, 32'd0);
        chk("flush_pready", 32'(bus_if.pipe_out_ready), 32'd0);
        chk("flush_uf", bus_if.underflow_count, 32'd0);
        bus_if.src_valid = 1'b1;
        bus_if.src_data  = 32'hA5A5_A5A5;
        step();
        bus_if.src_valid = 1'b0;
        chk("flush_a5_data", bus_if.pipe_out_data, 32'hA5A5_A5A5);
        chk("flush_a5_fill", 32'(bus_if.fill_level), 32'd1);

        // Asynchronous reset mid-cycle with 300 words buffered.
        bus_if.src_valid = 1'b1;
        for (int i = 0; i < 299; i++) begin
            bus_if.src_data = 32'(i + 7000);
            step();
        end
        bus_if.src_valid = 1'b0;
        chk("pre_rst_fill", 32'(bus_if.fill_level), 32'd300);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_src_ready", 32'(bus_if.src_ready), 32'd0);
        chk("arst_fill", 32'(bus_if.fill_level), 32'd0);
        chk("arst_data", bus_if.pipe_out_data, 32'd0);
        chk("arst_pready", 32'(bus_if.pipe_out_ready), 32'd0);
        chk("arst_uf", bus_if.underflow_count, 32'd0);
        step();
        reset_n = 1'b1;
        step();
        chk("arst_rel_src_ready", 32'(bus_if.src_ready), 32'd1);
        chk("arst_rel_data", bus_if.pipe_out_data, 32'd0);
        bus_if.src_valid = 1'b1;
        bus_if.src_data  = 32'hA5A5_A5A5;
        step();
        bus_if.src_valid = 1'b0;
        chk("arst_a5_data", bus_if.pipe_out_data, 32'hA5A5_A5A5);
        chk("arst_a5_fill", 32'(bus_if.fill_level), 32'd1);
        bus_if.pipe_out_read = 1'b1;
        step();
        bus_if.pipe_out_read = 1'b0;
        chk("arst_pop_fill", 32'(bus_if.fill_level), 32'd0);
        chk("arst_pop_hold", bus_if.pipe_out_data, 32'hA5A5_A5A5);
        bus_if.src_valid = 1'b1;
        bus_if.src_data  = 32'h1234_5678;
        step();
        bus_if.src_valid = 1'b0;
        chk("arst_new_data", bus_if.pipe_out_data, 32'h1234_5678);
        step();
        step();

        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
